// File: rtl/vm2002_stock_arbiter.sv
// Vending machine stock table (count and cost per item) shared by query, dispense and
// restock requesters through a round-robin arbiter; each access is an atomic read-modify-write.
module vm2002_stock_arbiter #(
   parameter int NUM_ITEMS = 7,
   parameter int CNT_W     = 5,
   parameter int COST_W    = 16,
   parameter int MAX_COUNT = 16
) (
   input  logic                 clk,
   input  logic                 hrst_n,
   input  logic                 q_req,
   input  logic [2:0]           q_item,
   output logic                 q_ack,
   output logic [CNT_W-1:0]     q_count,
   output logic [COST_W-1:0]    q_cost,
   input  logic                 v_req,
   input  logic [2:0]           v_item,
   output logic                 v_ack,
   output logic                 v_ok,
   input  logic                 r_req,
   input  logic [2:0]           r_item,
   input  logic [CNT_W-1:0]     r_count,
   input  logic [COST_W-1:0]    r_cost,
   output logic                 r_ack,
   output logic                 r_err,
   output logic [NUM_ITEMS-1:0] empty_vec
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;

   localparam logic [1:0]     GNT_Q    = 2'd0;
   localparam logic [1:0]     GNT_V    = 2'd1;
   localparam logic [1:0]     GNT_R    = 2'd2;
   localparam logic [3:0]     ITEM_LIM = 4'(NUM_ITEMS);
   localparam logic [CNT_W:0] MAX_SUM  = (CNT_W+1)'(MAX_COUNT);

   // Requester that follows g in the Q -> V -> R -> Q rotation.
   function automatic logic [1:0] rr_next(input logic [1:0] g);
      case (g)
         GNT_Q:   rr_next = GNT_V;
         GNT_V:   rr_next = GNT_R;
         default: rr_next = GNT_Q;
      endcase
   endfunction

   state_t              state_r;
   logic [1:0]          rr_r;
   logic [1:0]          gnt_r;
   logic [2:0]          item_r;
   logic [CNT_W-1:0]    add_r;
   logic [COST_W-1:0]   cost_in_r;
   logic [CNT_W-1:0]    count_r [NUM_ITEMS];
   logic [COST_W-1:0]   cost_r  [NUM_ITEMS];

   logic [3:0]          req_vec_s;
   logic [2:0]          cand_s;
   logic                win_valid_s;
   logic [1:0]          win_s;
   logic                item_ok_s;
   logic [CNT_W-1:0]    rd_count_s;
   logic [COST_W-1:0]   rd_cost_s;
   logic [CNT_W:0]      sum_s;
   logic                wr_en_s;
   logic [CNT_W-1:0]    wr_count_s;
   logic [COST_W-1:0]   wr_cost_s;
   logic                v_ok_s;
   logic                r_err_s;

   // Round-robin winner: scan from the pointer, nearest requester overrides farther ones.
   always_comb begin
      req_vec_s   = {1'b0, r_req, v_req, q_req};
      cand_s      = 3'd0;
      win_valid_s = 1'b0;
      win_s       = rr_r;
      for (int i = 2; i >= 0; i--) begin
         cand_s = {1'b0, rr_r} + 3'(i);
         if (cand_s > 3'd2) begin
            cand_s = cand_s - 3'd3;
         end else begin
            cand_s = cand_s;
         end
         win_valid_s = win_valid_s | req_vec_s[cand_s[1:0]];
         win_s       = req_vec_s[cand_s[1:0]] ? cand_s[1:0] : win_s;
      end
   end

   // Read the latched entry and compute the access result for the granted requester.
   always_comb begin
      item_ok_s  = ({1'b0, item_r} < ITEM_LIM);
      rd_count_s = '0;
      rd_cost_s  = '0;
      if (item_ok_s) begin
         rd_count_s = count_r[item_r];
         rd_cost_s  = cost_r[item_r];
      end else begin
         rd_count_s = '0;
         rd_cost_s  = '0;
      end
      sum_s      = {1'b0, rd_count_s} + {1'b0, add_r};
      wr_en_s    = 1'b0;
      wr_count_s = rd_count_s;
      wr_cost_s  = rd_cost_s;
      v_ok_s     = 1'b0;
      r_err_s    = 1'b0;
      case (gnt_r)
         GNT_V: begin
            if (item_ok_s && (rd_count_s != '0)) begin
               wr_en_s    = 1'b1;
               wr_count_s = rd_count_s - CNT_W'(1);
               v_ok_s     = 1'b1;
            end else begin
               v_ok_s     = 1'b0;
            end
         end
         GNT_R: begin
            // An overflowing restock is rejected whole, including the price change.
            if (!item_ok_s || (sum_s > MAX_SUM)) begin
               r_err_s = 1'b1;
            end else begin
               wr_en_s    = 1'b1;
               wr_count_s = sum_s[CNT_W-1:0];
               wr_cost_s  = (cost_in_r != '0) ? cost_in_r : rd_cost_s;
            end
         end
         default: begin
            wr_en_s = 1'b0;
         end
      endcase
   end

   // Arbitration FSM, stock table and registered result outputs.
   always_ff @(posedge clk or negedge hrst_n) begin
      if (!hrst_n) begin
         state_r   <= ST_IDLE;
         rr_r      <= GNT_Q;
         gnt_r     <= GNT_Q;
         item_r    <= 3'd0;
         add_r     <= '0;
         cost_in_r <= '0;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            count_r[i] <= '0;
            cost_r[i]  <= '0;
         end
         q_ack     <= 1'b0;
         q_count   <= '0;
         q_cost    <= '0;
         v_ack     <= 1'b0;
         v_ok      <= 1'b0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         empty_vec <= '1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (win_valid_s) begin
                  gnt_r   <= win_s;
                  state_r <= ST_EXEC;
                  case (win_s)
                     GNT_Q: begin
                        item_r    <= q_item;
                        add_r     <= '0;
                        cost_in_r <= '0;
                     end
                     GNT_V: begin
                        item_r    <= v_item;
                        add_r     <= '0;
                        cost_in_r <= '0;
                     end
                     default: begin
                        item_r    <= r_item;
                        add_r     <= r_count;
                        cost_in_r <= r_cost;
                     end
                  endcase
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               if (wr_en_s) begin
                  count_r[item_r]   <= wr_count_s;
                  cost_r[item_r]    <= wr_cost_s;
                  empty_vec[item_r] <= (wr_count_s == '0);
               end else begin
                  empty_vec <= empty_vec;
               end
               case (gnt_r)
                  GNT_Q: begin
                     q_ack   <= 1'b1;
                     q_count <= rd_count_s;
                     q_cost  <= rd_cost_s;
                  end
                  GNT_V: begin
                     v_ack <= 1'b1;
                     v_ok  <= v_ok_s;
                  end
                  default: begin
                     r_ack <= 1'b1;
                     r_err <= r_err_s;
                  end
               endcase
               state_r <= ST_DONE;
            end
            ST_DONE: begin
               q_ack   <= 1'b0;
               v_ack   <= 1'b0;
               r_ack   <= 1'b0;
               rr_r    <= rr_next(gnt_r);
               state_r <= ST_IDLE;
            end
            default: begin
               q_ack   <= 1'b0;
               v_ack   <= 1'b0;
               r_ack   <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vm2002_stock_arbiter.sv
// Self-checking bench for vm2002_stock_arbiter: vector table through a scoreboard queue,
// then concurrent-request, same-item race and mid-access reset sequences.
module tb_vm2002_stock_arbiter;

   localparam logic [1:0] K_Q = 2'd0;
   localparam logic [1:0] K_V = 2'd1;
   localparam logic [1:0] K_R = 2'd2;

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  item;
      logic [4:0]  cnt;
      logic [15:0] cost;
      logic [4:0]  e_count;
      logic [15:0] e_cost;
      logic        e_flag;
      logic [6:0]  e_empty;
   } vec_t;

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  count;
      logic [15:0] cost;
      logic        flag;
      logic [6:0]  empty;
   } exp_t;

   logic        clk = 1'b0;
   logic        hrst_n;
   logic        q_req, v_req, r_req;
   logic [2:0]  q_item, v_item, r_item;
   logic [4:0]  r_count;
   logic [15:0] r_cost;
   logic        q_ack, v_ack, r_ack, v_ok, r_err;
   logic [4:0]  q_count;
   logic [15:0] q_cost;
   logic [6:0]  empty_vec;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   vec_t vecs[18];

   vm2002_stock_arbiter dut (
      .clk(clk), .hrst_n(hrst_n),
      .q_req(q_req), .q_item(q_item), .q_ack(q_ack), .q_count(q_count), .q_cost(q_cost),
      .v_req(v_req), .v_item(v_item), .v_ack(v_ack), .v_ok(v_ok),
      .r_req(r_req), .r_item(r_item), .r_count(r_count), .r_cost(r_cost),
      .r_ack(r_ack), .r_err(r_err), .empty_vec(empty_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic ack_of(input logic [1:0] k);
      case (k)
         K_Q:     return q_ack;
         K_V:     return v_ack;
         default: return r_ack;
      endcase
   endfunction

   // One handshake: push expectation, drive, wait bounded for ack, pop and compare.
   task automatic access(input vec_t v);
      exp_t e;
      int   n;
      logic got;
      e.kind = v.kind; e.count = v.e_count; e.cost = v.e_cost;
      e.flag = v.e_flag; e.empty = v.e_empty;
      exp_q.push_back(e);
      case (v.kind)
         K_Q:     begin q_item = v.item; q_req = 1'b1; end
         K_V:     begin v_item = v.item; v_req = 1'b1; end
         default: begin r_item = v.item; r_count = v.cnt; r_cost = v.cost; r_req = 1'b1; end
      endcase
      n = 0;
      got = 1'b0;
      while (!got && n < 8) begin
         @(posedge clk); #1;
         n++;
         got = ack_of(v.kind);
      end
      q_req = 1'b0; v_req = 1'b0; r_req = 1'b0;
      chk("ack_latency", n, 2);
      e = exp_q.pop_front();
      case (e.kind)
         K_Q: begin
            chk("q_count", q_count, e.count);
            chk("q_cost", q_cost, e.cost);
         end
         K_V:     chk("v_ok", v_ok, e.flag);
         default: chk("r_err", r_err, e.flag);
      endcase
      chk("empty_vec", empty_vec, e.empty);
      @(posedge clk); #1;
      chk("ack_pulse", ack_of(e.kind), 1'b0);
   endtask

   initial begin
      int q_at, v_at, r_at;
      logic [4:0]  cap_cnt;
      logic [15:0] cap_cost;
      logic cap_ok, cap_err, stray;

      vecs[0]  = '{K_R, 3'd2, 5'd5,  16'h004B, 5'd0,  16'h0000, 1'b0, 7'b1111011};
      vecs[1]  = '{K_Q, 3'd2, 5'd0,  16'h0000, 5'd5,  16'h004B, 1'b0, 7'b1111011};
      vecs[2]  = '{K_R, 3'd2, 5'd11, 16'h0000, 5'd0,  16'h0000, 1'b0, 7'b1111011};
      vecs[3]  = '{K_R, 3'd2, 5'd1,  16'h0099, 5'd0,  16'h0000, 1'b1, 7'b1111011};
      vecs[4]  = '{K_Q, 3'd2, 5'd0,  16'h0000, 5'd16, 16'h004B, 1'b0, 7'b1111011};
      vecs[5]  = '{K_R, 3'd2, 5'd0,  16'h0032, 5'd0,  16'h0000, 1'b0, 7'b1111011};
      vecs[6]  = '{K_Q, 3'd2, 5'd0,  16'h0000, 5'd16, 16'h0032, 1'b0, 7'b1111011};
      vecs[7]  = '{K_V, 3'd0, 5'd0,  16'h0000, 5'd0,  16'h0000, 1'b0, 7'b1111011};
      vecs[8]  = '{K_Q, 3'd0, 5'd0,  16'h0000, 5'd0,  16'h0000, 1'b0, 7'b1111011};
      vecs[9]  = '{K_R, 3'd0, 5'd1,  16'h0010, 5'd0,  16'h0000, 1'b0, 7'b1111010};
      vecs[10] = '{K_V, 3'd0, 5'd0,  16'h0000, 5'd0,  16'h0000, 1'b1, 7'b1111011};
      vecs[11] = '{K_Q, 3'd0, 5'd0,  16'h0000, 5'd0,  16'h0010, 1'b0, 7'b1111011};
      vecs[12] = '{K_R, 3'd7, 5'd1,  16'h0001, 5'd0,  16'h0000, 1'b1, 7'b1111011};
      vecs[13] = '{K_V, 3'd7, 5'd0,  16'h0000, 5'd0,  16'h0000, 1'b0, 7'b1111011};
      vecs[14] = '{K_Q, 3'd7, 5'd0,  16'h0000, 5'd0,  16'h0000, 1'b0, 7'b1111011};
      vecs[15] = '{K_V, 3'd2, 5'd0,  16'h0000, 5'd0,  16'h0000, 1'b1, 7'b1111011};
      vecs[16] = '{K_Q, 3'd2, 5'd0,  16'h0000, 5'd15, 16'h0032, 1'b0, 7'b1111011};
      vecs[17] = '{K_R, 3'd2, 5'd1,  16'h0000, 5'd0,  16'h0000, 1'b0, 7'b1111011};

      q_req = 1'b0; v_req = 1'b0; r_req = 1'b0;
      q_item = 3'd0; v_item = 3'd0; r_item = 3'd0; r_count = 5'd0; r_cost = 16'h0000;
      hrst_n = 1'b1;
      #2 hrst_n = 1'b0;
      #20;
      chk("rst_acks", {q_ack, v_ack, r_ack}, 3'b000);
      chk("rst_flags", {v_ok, r_err}, 2'b00);
      chk("rst_q_count", q_count, 5'd0);
      chk("rst_q_cost", q_cost, 16'h0000);
      chk("rst_empty_vec", empty_vec, 7'b1111111);
      hrst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) access(vecs[i]);

      // All three requesters raised together: grants Q, V, R, three cycles apart.
      q_item = 3'd2; v_item = 3'd2; r_item = 3'd3; r_count = 5'd2; r_cost = 16'h0020;
      q_req = 1'b1; v_req = 1'b1; r_req = 1'b1;
      q_at = 0; v_at = 0; r_at = 0;
      cap_cnt = 5'd0; cap_cost = 16'h0000; cap_ok = 1'b0; cap_err = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (q_ack) begin q_at = c; q_req = 1'b0; cap_cnt = q_count; cap_cost = q_cost; end
         if (v_ack) begin v_at = c; v_req = 1'b0; cap_ok = v_ok; end
         if (r_ack) begin r_at = c; r_req = 1'b0; cap_err = r_err; end
      end
      chk("rr_q_at", q_at, 2);
      chk("rr_v_at", v_at, 5);
      chk("rr_r_at", r_at, 8);
      chk("rr_q_count", cap_cnt, 5'd16);
      chk("rr_q_cost", cap_cost, 16'h0032);
      chk("rr_v_ok", cap_ok, 1'b1);
      chk("rr_r_err", cap_err, 1'b0);
      access('{K_Q, 3'd2, 5'd0, 16'h0000, 5'd15, 16'h0032, 1'b0, 7'b1110011});

      // Dispense and restock racing on one item: both updates must land.
      access('{K_R, 3'd4, 5'd3, 16'h0055, 5'd0, 16'h0000, 1'b0, 7'b1100011});
      v_item = 3'd4; r_item = 3'd4; r_count = 5'd2; r_cost = 16'h0000;
      v_req = 1'b1; r_req = 1'b1;
      v_at = 0; r_at = 0; cap_ok = 1'b0; cap_err = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (v_ack) begin v_at = c; v_req = 1'b0; cap_ok = v_ok; end
         if (r_ack) begin r_at = c; r_req = 1'b0; cap_err = r_err; end
      end
      chk("race_v_at", v_at, 2);
      chk("race_r_at", r_at, 5);
      chk("race_v_ok", cap_ok, 1'b1);
      chk("race_r_err", cap_err, 1'b0);
      access('{K_Q, 3'd4, 5'd0, 16'h0000, 5'd4, 16'h0055, 1'b0, 7'b1100011});

      // Reset while a restock is in EXEC: no ack, no write, table cleared.
      r_item = 3'd5; r_count = 5'd3; r_cost = 16'h0077; r_req = 1'b1;
      @(posedge clk); #1;
      hrst_n = 1'b0;
      #1;
      r_req = 1'b0;
      chk("midrst_r_ack", r_ack, 1'b0);
      chk("midrst_empty_vec", empty_vec, 7'b1111111);
      #2 hrst_n = 1'b1;
      stray = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         stray = stray | q_ack | v_ack | r_ack;
      end
      chk("midrst_no_ack", stray, 1'b0);
      access('{K_Q, 3'd5, 5'd0, 16'h0000, 5'd0, 16'h0000, 1'b0, 7'b1111111});
      access('{K_Q, 3'd2, 5'd0, 16'h0000, 5'd0, 16'h0000, 1'b0, 7'b1111111});
      access('{K_V, 3'd7, 5'd0, 16'h0000, 5'd0, 16'h0000, 1'b0, 7'b1111111});
      access('{K_R, 3'd7, 5'd1, 16'h0001, 5'd0, 16'h0000, 1'b1, 7'b1111111});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
